// File: rtl/synth_ctrl_pkg.sv
// synth_ctrl_pkg
// Shared definitions for the synth control register file and its masters.
// Holds the word-address map of the control register slave (SHAPE, ADSR,
// GLIDE, ARP, KEY, FREQ, AMP banks), the KEY register values, the state
// encoding of note_voice_master and a helper that packs a note into a
// FREQ register word.
package synth_ctrl_pkg;

    // Control register map (word addresses, 8 words reserved per bank)
    localparam int REG_SHAPE_BASE = 0;
    localparam int REG_ADSR_BASE  = 8;
    localparam int REG_GLIDE_BASE = 16;
    localparam int REG_ARP_BASE   = 24;
    localparam int REG_KEY_BASE   = 32;
    localparam int REG_FREQ_BASE  = 40;
    localparam int REG_AMP_BASE   = 48;
    localparam int REG_MAP_WORDS  = 64;

    // KEYn register contents
    localparam logic [31:0] KEY_OFF_WORD = 32'd0;
    localparam logic [31:0] KEY_ON_WORD  = 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WR_KOFF,
        WR_FREQ,
        WR_KON
    } nvm_state_t;

    // FREQn holds the raw 7-bit note number, zero-extended
    function automatic logic [31:0] freq_word(input logic [6:0] note);
        return {25'd0, note};
    endfunction

endpackage

// File: rtl/note_voice_master_voice_allocator.sv
// voice_allocator
// Picks the voice an event applies to, from the shadow key state.
// Ports:
//   CLK, RESET    clock, synchronous active-high reset
//   lookup        high for the single allocation cycle
//   ev_on, ev_note   captured event (1 = note-on)
//   voice_active  shadow active bit per voice
//   voice_notes   shadow note per voice, 7 bits each, voice 0 in the LSBs
//   voice_idx     selected voice
//   hit           an active voice already holds ev_note
//   free          at least one voice is inactive
//   none          neither hit nor free (steal on note-on, drop on note-off)
module voice_allocator
    import synth_ctrl_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    lookup,
    input  logic                    ev_on,
    input  logic [6:0]              ev_note,
    input  logic [NUM_VOICES-1:0]   voice_active,
    input  logic [NUM_VOICES*7-1:0] voice_notes,
    output logic [VW-1:0]           voice_idx,
    output logic                    hit,
    output logic                    free,
    output logic                    none
);

    logic [VW-1:0] hit_idx;
    logic [VW-1:0] free_idx;
    logic [VW-1:0] steal_ptr;
    logic          steal;

    // Scanning from the top down lets the lowest matching index overwrite
    // the others, so ties resolve to the lowest voice.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (voice_active[v] && (voice_notes[v*7 +: 7] == ev_note)) begin
                hit     = 1'b1;
                hit_idx = VW'(v);
            end
            if (!voice_active[v]) begin
                free     = 1'b1;
                free_idx = VW'(v);
            end
        end
    end

    assign none = !hit && !free;

    always_comb begin
        voice_idx = hit_idx;
        if (ev_on && !hit) begin
            voice_idx = free ? free_idx : steal_ptr;
        end
    end

    // The pointer only moves when a steal is actually taken.
    assign steal = lookup && ev_on && none;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            steal_ptr <= '0;
        end else if (steal) begin
            steal_ptr <= (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/note_voice_master.sv
// note_voice_master
// Avalon-MM write master turning note-on/note-off events into FREQn/KEYn
// register writes on the synth control register file, managing NUM_VOICES
// voices with retrigger, lowest-free allocation and round-robin stealing.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   EV_VALID/EV_READY   event handshake; EV_ON (1 = note-on), EV_NOTE
//   AVM_*               Avalon-MM write master (word addresses)
//   VOICE_ACTIVE        shadow key state per voice
//   BUSY                an event is being processed
module note_voice_master
    import synth_ctrl_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int KEY_BASE   = REG_KEY_BASE,
    parameter int FREQ_BASE  = REG_FREQ_BASE
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EV_VALID,
    output logic                  EV_READY,
    input  logic                  EV_ON,
    input  logic [6:0]            EV_NOTE,
    output logic [5:0]            AVM_ADDR,
    output logic                  AVM_WRITE,
    output logic                  AVM_CS,
    output logic [3:0]            AVM_BYTE_EN,
    output logic [31:0]           AVM_WRITEDATA,
    input  logic                  AVM_WAITREQUEST,
    output logic [NUM_VOICES-1:0] VOICE_ACTIVE,
    output logic                  BUSY
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    nvm_state_t state;
    nvm_state_t state_next;

    logic                    on_q;
    logic [6:0]              note_q;
    logic [VW-1:0]           voice_q;
    logic [NUM_VOICES-1:0]   active_q;
    logic [NUM_VOICES*7-1:0] notes_q;

    logic [VW-1:0] alloc_idx;
    logic          alloc_hit;
    logic          alloc_free;
    logic          alloc_none;
    logic          accept;
    logic [5:0]    key_addr;
    logic [5:0]    freq_addr;

    voice_allocator #(
        .NUM_VOICES (NUM_VOICES),
        .VW         (VW)
    ) u_alloc (
        .CLK          (CLK),
        .RESET        (RESET),
        .lookup       (state == LOOKUP),
        .ev_on        (on_q),
        .ev_note      (note_q),
        .voice_active (active_q),
        .voice_notes  (notes_q),
        .voice_idx    (alloc_idx),
        .hit          (alloc_hit),
        .free         (alloc_free),
        .none         (alloc_none)
    );

    // A write completes on any cycle the slave does not stall.
    assign accept = !AVM_WAITREQUEST;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (EV_VALID) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (on_q) begin
                    state_next = (alloc_free && !alloc_hit) ? WR_FREQ : WR_KOFF;
                end else begin
                    state_next = alloc_hit ? WR_KOFF : IDLE;
                end
            end
            WR_KOFF: begin
                if (accept) begin
                    state_next = on_q ? WR_FREQ : IDLE;
                end
            end
            WR_FREQ: begin
                if (accept) begin
                    state_next = WR_KON;
                end
            end
            WR_KON: begin
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The event is latched on the handshake; the voice is latched at the
    // end of LOOKUP so the write states decode purely from registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            on_q    <= 1'b0;
            note_q  <= '0;
            voice_q <= '0;
        end else begin
            if (state == IDLE && EV_VALID) begin
                on_q   <= EV_ON;
                note_q <= EV_NOTE;
            end
            if (state == LOOKUP) begin
                voice_q <= alloc_idx;
            end
        end
    end

    // A forced key-off inside a retrigger or steal keeps the shadow as is;
    // only a note-off event clears it, and key-on commits the new note.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            active_q <= '0;
            notes_q  <= '0;
        end else if (state == WR_KON && accept) begin
            active_q[voice_q]             <= 1'b1;
            notes_q[int'(voice_q)*7 +: 7] <= note_q;
        end else if (state == WR_KOFF && accept && !on_q) begin
            active_q[voice_q] <= 1'b0;
        end
    end

    assign key_addr  = 6'(KEY_BASE + int'(voice_q));
    assign freq_addr = 6'(FREQ_BASE + int'(voice_q));

    always_comb begin
        AVM_WRITE     = 1'b0;
        AVM_ADDR      = '0;
        AVM_WRITEDATA = '0;
        case (state)
            WR_KOFF: begin
                AVM_WRITE     = 1'b1;
                AVM_ADDR      = key_addr;
                AVM_WRITEDATA = KEY_OFF_WORD;
            end
            WR_FREQ: begin
                AVM_WRITE     = 1'b1;
                AVM_ADDR      = freq_addr;
                AVM_WRITEDATA = freq_word(note_q);
            end
            WR_KON: begin
                AVM_WRITE     = 1'b1;
                AVM_ADDR      = key_addr;
                AVM_WRITEDATA = KEY_ON_WORD;
            end
            default: begin
                AVM_WRITE     = 1'b0;
            end
        endcase
    end

    assign AVM_CS       = AVM_WRITE;
    assign AVM_BYTE_EN  = 4'hF;
    // Ready is held low for the whole reset assertion, not just after it.
    assign EV_READY     = (state == IDLE) && !RESET;
    assign BUSY         = (state != IDLE);
    assign VOICE_ACTIVE = active_q;

endmodule

// File: doc/note_voice_master.md
# note_voice_master

Avalon-MM write master that drives the synth control register file from note events. It accepts note-on and note-off events over a valid/ready handshake and allocates one of four voices. It then issues the FREQn/KEYn register writes needed to start, retrigger or release that voice. It sits between the keyboard/MIDI front end and the control register slave, sharing its clock, reset and register map.

## Interface
Parameters:
- NUM_VOICES, 4, voices managed; one FREQ and one KEY register each
- KEY_BASE, 32, word address of KEY0; voice v uses KEY_BASE+v
- FREQ_BASE, 40, word address of FREQ0; voice v uses FREQ_BASE+v

Ports:
- CLK  in  1  clock
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK
- EV_VALID  in  1  event present
- EV_READY  out  1  block can accept an event
- EV_ON  in  1  1 = note-on, 0 = note-off
- EV_NOTE  in  7  note number 0..127
- AVM_ADDR  out  6  word address
- AVM_WRITE  out  1  write request
- AVM_CS  out  1  chip select; equals AVM_WRITE
- AVM_BYTE_EN  out  4  constant 4'hF
- AVM_WRITEDATA  out  32  write data
- AVM_WAITREQUEST  in  1  slave stall; tie 0 for the zero-wait register file
- VOICE_ACTIVE  out  NUM_VOICES  shadow key state per voice
- BUSY  out  1  state != IDLE

## Operation
- States: IDLE, LOOKUP, WR_KOFF, WR_FREQ, WR_KON.
- IDLE:
  - EV_READY=1.
  - When EV_VALID&EV_READY, capture EV_ON/EV_NOTE and go to LOOKUP.
- LOOKUP (one cycle, EV_READY=0): allocation, lowest index wins on ties.
  - Note-on, note already held by active voice v: retrigger v. Next state WR_KOFF.
  - Note-on, a free voice exists: take the lowest free v. Next state WR_FREQ.
  - Note-on, all voices active: steal v = steal_ptr, then steal_ptr = (steal_ptr+1) mod NUM_VOICES. Next state WR_KOFF.
  - Note-off, an active voice holds the note: take v. Next state WR_KOFF.
  - Note-off, no active voice holds the note: drop the event, no bus traffic. Next state IDLE.
- Write states:
  - AVM_WRITE=AVM_CS=1, address and data held stable until a cycle with AVM_WAITREQUEST=0 (the accept cycle).
  - The state advances on the edge ending the accept cycle.
- Write contents:
  - WR_KOFF: ADDR=KEY_BASE+v, DATA=32'd0. Then WR_FREQ for a note-on event, IDLE for a note-off event.
  - WR_FREQ: ADDR=FREQ_BASE+v, DATA={25'd0, note}. Then WR_KON.
  - WR_KON: ADDR=KEY_BASE+v, DATA=32'd1. Then IDLE.
- Shadow state per voice (active bit, 7-bit note):
  - Set active[v]=1 and note[v] on WR_KON accept.
  - Clear active[v] on WR_KOFF accept for a note-off event.
  - A forced KEY=0 inside a retrigger or steal leaves the shadow unchanged until WR_KON.
- Outside write states: AVM_WRITE=AVM_CS=0, AVM_ADDR=0, AVM_WRITEDATA=0.

## Timing
- Reset values: state IDLE, EV_READY=0 while RESET is high, then 1 on the first cycle after RESET falls. AVM_WRITE=AVM_CS=0, AVM_ADDR=0, AVM_WRITEDATA=0, VOICE_ACTIVE=0, steal_ptr=0, BUSY=0.
- AVM_* outputs decode from registered state and captured event only. No combinational path from AVM_WAITREQUEST or EV_* to any output.
- Latency with AVM_WAITREQUEST=0, event accepted at cycle T (LOOKUP at T+1, first write at T+2):

| Event | Writes | Back in IDLE |
|---|---|---|
| Free-voice note-on | FREQ at T+2, KON at T+3 | T+4 |
| Retrigger/steal note-on | KOFF at T+2, FREQ at T+3, KON at T+4 | T+5 |
| Matched note-off | KOFF at T+2 | T+3 |
| Unmatched note-off | none | T+2 |

- Each AVM_WAITREQUEST=1 cycle extends the current write by one cycle.
- One event in flight; EV_READY=0 from LOOKUP until return to IDLE.
- RESET mid-transaction aborts at the same edge: AVM_WRITE drops and shadow state clears. The slave register file resets on the same RESET, so both sides stay consistent.
- Note numbers use full 7 bits; no clamping.

## Structure
- Package synth_ctrl_pkg:
  - KEY_BASE/FREQ_BASE address constants.
  - State enum nvm_state_t.
  - The full control register map constants (SHAPE, ADSR, GLIDE, ARP, KEY, FREQ, AMP) shared with the register slave.
- Sub-module voice_allocator:
  - Combinational match/free/steal selection from the shadow arrays.
  - Owns the steal_ptr register.
  - Outputs: voice index, hit/free/none flags.
- Top holds the FSM, event capture, shadow update and bus drive.

## Test plan
- Reset, then note-on 60, no waitrequest → writes (40, 60) then (32, 1) on consecutive cycles; VOICE_ACTIVE=4'b0001; EV_READY back at T+4.
- Note-ons 60, 62, 64, 65, then 67 → 67 steals voice 0: (32, 0), (40, 67), (32, 1); steal_ptr=1. A further note-on 69 steals voice 1.
- Note-off 62 with voices holding 60/62 → single write (33, 0); VOICE_ACTIVE bit1 clears. Note-off 99 → no AVM_WRITE; IDLE at T+2.
- Note-on 60 while 60 already held on voice 0 → (32, 0), (40, 60), (32, 1); no other voice touched.
- AVM_WAITREQUEST high for 3 cycles during WR_FREQ → ADDR/DATA stable for 4 cycles; exactly one accepted write; EV_READY stays 0.
- RESET asserted during WR_FREQ → AVM_WRITE=0 and VOICE_ACTIVE=0 next cycle; a following note-on 72 goes to voice 0.
